// File: rtl/dsc_mul_ctrl.sv
// Sequencing controller for a dsc_mul stochastic multiplier: accepts an operand set, clears and
// runs the multiplier, times the run, and holds the product until the consumer takes it.
module dsc_mul_ctrl #(
    parameter int NUM_BITS   = 6,
    parameter int NUM_INPUTS = 4,
    parameter int CW         = 26,
    parameter int LIMIT      = 2**24 + 16
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_BITS-1:0]            in_a,
    input  logic [NUM_BITS-1:0]            in_b,
    input  logic [NUM_BITS-1:0]            in_c,
    input  logic [NUM_BITS-1:0]            in_d,

    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_INPUTS*NUM_BITS-1:0] out_z,
    output logic [CW-1:0]                  out_cycles,
    output logic                           out_timeout,

    output logic                           mul_rst,
    output logic                           mul_en,
    output logic [NUM_BITS-1:0]            mul_a,
    output logic [NUM_BITS-1:0]            mul_b,
    output logic [NUM_BITS-1:0]            mul_c,
    output logic [NUM_BITS-1:0]            mul_d,
    input  logic [NUM_INPUTS*NUM_BITS-1:0] mul_z,
    input  logic                           mul_ov
);

    localparam int ZW = NUM_INPUTS * NUM_BITS;

    localparam logic [CW-1:0] LIM     = CW'(LIMIT);
    localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CLR  = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [CW-1:0]       cnt_inc;
    logic [ZW-1:0]       z_q, z_d;
    logic [CW-1:0]       cycles_q, cycles_d;
    logic                timeout_q, timeout_d;
    logic [NUM_BITS-1:0] a_q, a_d;
    logic [NUM_BITS-1:0] b_q, b_d;
    logic [NUM_BITS-1:0] c_q, c_d;
    logic [NUM_BITS-1:0] d_q, d_d;
    logic                alive_q;
    logic                accept;
    logic                any_zero;

    // alive_q keeps in_ready low until the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alive_q <= 1'b0;
        end else begin
            alive_q <= 1'b1;
        end
    end

    assign in_ready  = (state_q == IDLE) && alive_q;
    assign out_valid = (state_q == DONE);
    assign mul_en    = (state_q == RUN);
    assign mul_rst   = (state_q != RUN);

    assign out_z       = z_q;
    assign out_cycles  = cycles_q;
    assign out_timeout = timeout_q;
    assign mul_a       = a_q;
    assign mul_b       = b_q;
    assign mul_c       = c_q;
    assign mul_d       = d_q;

    assign accept   = in_valid && in_ready;
    assign any_zero = (in_a == '0) || (in_b == '0) || (in_c == '0) || (in_d == '0);

    // Saturating increment: the count never wraps past LIMIT.
    assign cnt_inc = (cnt_q >= LIM) ? LIM : cnt_q + CNT_ONE;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        z_d       = z_q;
        cycles_d  = cycles_q;
        timeout_d = timeout_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        d_d       = d_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_d   = in_a;
                    b_d   = in_b;
                    c_d   = in_c;
                    d_d   = in_d;
                    cnt_d = '0;
                    if (any_zero) begin
                        z_d       = '0;
                        cycles_d  = '0;
                        timeout_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        state_d = CLR;
                    end
                end
            end
            CLR: begin
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_inc;
                // A finishing multiplier beats a simultaneous timeout.
                if (mul_ov) begin
                    z_d       = mul_z;
                    cycles_d  = cnt_inc;
                    timeout_d = 1'b0;
                    state_d   = DONE;
                end else if (cnt_inc == LIM) begin
                    z_d       = '0;
                    cycles_d  = LIM;
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            z_q       <= '0;
            cycles_q  <= '0;
            timeout_q <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            c_q       <= '0;
            d_q       <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            z_q       <= z_d;
            cycles_q  <= cycles_d;
            timeout_q <= timeout_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
        end
    end

endmodule

// File: tb/tb_dsc_mul_ctrl.sv
// Directed bench for dsc_mul_ctrl: a behavioural fixed-latency multiplier model on the main
// instance, and a never-finishing stub on a second instance with a short timeout.
module tb_dsc_mul_ctrl;

    localparam int NB  = 6;
    localparam int ZW  = 24;
    localparam int CW  = 26;
    localparam int LAT = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_valid_t = 1'b0;
    logic          out_ready = 1'b0, out_ready_t = 1'b0;
    logic [NB-1:0] in_a = '0, in_b = '0, in_c = '0, in_d = '0;

    logic          in_ready, out_valid, out_timeout, mul_rst, mul_en, mul_ov;
    logic [ZW-1:0] out_z, mul_z;
    logic [CW-1:0] out_cycles;
    logic [NB-1:0] mul_a, mul_b, mul_c, mul_d;

    logic          in_ready_t, out_valid_t, out_timeout_t, mul_rst_t, mul_en_t;
    logic [ZW-1:0] out_z_t;
    logic [CW-1:0] out_cycles_t;
    logic [NB-1:0] mul_a_t, mul_b_t, mul_c_t, mul_d_t;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dsc_mul_ctrl u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_z(out_z), .out_cycles(out_cycles), .out_timeout(out_timeout),
        .mul_rst(mul_rst), .mul_en(mul_en),
        .mul_a(mul_a), .mul_b(mul_b), .mul_c(mul_c), .mul_d(mul_d),
        .mul_z(mul_z), .mul_ov(mul_ov)
    );

    dsc_mul_ctrl #(.LIMIT(20)) u_dut_to (
        .clk(clk), .rst(rst),
        .in_valid(in_valid_t), .in_ready(in_ready_t),
        .in_a(in_a), .in_b(in_b), .in_c(in_c), .in_d(in_d),
        .out_valid(out_valid_t), .out_ready(out_ready_t),
        .out_z(out_z_t), .out_cycles(out_cycles_t), .out_timeout(out_timeout_t),
        .mul_rst(mul_rst_t), .mul_en(mul_en_t),
        .mul_a(mul_a_t), .mul_b(mul_b_t), .mul_c(mul_c_t), .mul_d(mul_d_t),
        .mul_z({ZW{1'b1}}), .mul_ov(1'b0)
    );

    // Multiplier model: finishes in the LAT-th enabled cycle after a clear.
    int mcnt;
    always_ff @(posedge clk) begin
        if (mul_rst) mcnt <= 0;
        else if (mul_en) mcnt <= mcnt + 1;
    end
    assign mul_ov = mul_en && (mcnt == LAT - 1);
    assign mul_z  = ZW'(mul_a) * ZW'(mul_b) * ZW'(mul_c) * ZW'(mul_d);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [NB-1:0] a, b, c, d);
        in_a = a; in_b = b; in_c = c; in_d = d;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Runs the main instance until out_valid, counting mul_en-high cycles.
    task automatic wait_done(output int en_cnt, output bit ok);
        en_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            if (mul_en) en_cnt++;
            tick();
        end
    endtask

    task automatic take();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int  en_cnt;
    bit  ok;

    initial begin
        // Reset held for three cycles.
        rst = 1'b1;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_z", out_z, 0);
        check("rst_out_cycles", out_cycles, 0);
        check("rst_out_timeout", out_timeout, 0);
        check("rst_mul_rst", mul_rst, 1);
        check("rst_mul_en", mul_en, 0);
        check("rst_mul_a", {mul_a, mul_b, mul_c, mul_d}, 0);
        rst = 1'b0;
        #1;
        check("rel_in_ready_low", in_ready, 0);
        tick();
        check("rel_in_ready", in_ready, 1);

        // Normal product 3*5*7*2.
        offer(3, 5, 7, 2);
        check("nrm_clr_mul_rst", mul_rst, 1);
        check("nrm_clr_mul_en", mul_en, 0);
        check("nrm_latch_a", mul_a, 3);
        tick();
        check("nrm_run_mul_en", mul_en, 1);
        check("nrm_run_mul_rst", mul_rst, 0);
        wait_done(en_cnt, ok);
        check("nrm_done_seen", ok, 1);
        check("nrm_out_z", out_z, 210);
        check("nrm_timeout", out_timeout, 0);
        check("nrm_cycles_vs_en", out_cycles, en_cnt);
        check("nrm_cycles", out_cycles, LAT);
        take();
        check("nrm_valid_drop", out_valid, 0);
        check("nrm_idle_ready", in_ready, 1);

        // Zero fast path.
        offer(0, 63, 63, 63);
        check("zero_valid", out_valid, 1);
        check("zero_out_z", out_z, 0);
        check("zero_cycles", out_cycles, 0);
        check("zero_timeout", out_timeout, 0);
        check("zero_mul_en", mul_en, 0);
        take();

        // Backpressure on 63^4, with a competing operand set offered throughout.
        offer(63, 63, 63, 63);
        wait_done(en_cnt, ok);
        check("bp_done_seen", ok, 1);
        in_a = 4; in_b = 1; in_c = 1; in_d = 1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp_out_z_hold", out_z, 15752961);
            check("bp_in_ready", in_ready, 0);
            tick();
        end
        check("bp_valid_hold", out_valid, 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("bp_no_early_accept", mul_a, 63);
        check("bp_idle_ready", in_ready, 1);
        tick();
        in_valid = 1'b0;
        check("bp_next_accept", mul_a, 4);
        wait_done(en_cnt, ok);
        check("bp_next_out_z", out_z, 4);
        take();

        // Timeout on the stub instance.
        in_a = 1; in_b = 1; in_c = 1; in_d = 1;
        in_valid_t = 1'b1;
        tick();
        in_valid_t = 1'b0;
        en_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (out_valid_t) begin
                ok = 1'b1;
                break;
            end
            if (mul_en_t) en_cnt++;
            tick();
        end
        check("to_done_seen", ok, 1);
        check("to_timeout", out_timeout_t, 1);
        check("to_cycles", out_cycles_t, 20);
        check("to_out_z", out_z_t, 0);
        check("to_en_cycles", en_cnt, 20);
        out_ready_t = 1'b1;
        tick();
        out_ready_t = 1'b0;

        // Abort during the 5th RUN cycle.
        offer(3, 3, 3, 3);
        tick();
        repeat (4) tick();
        check("ab_in_run", mul_en, 1);
        rst = 1'b1;
        #1;
        check("ab_mul_en", mul_en, 0);
        check("ab_mul_rst", mul_rst, 1);
        check("ab_out_valid", out_valid, 0);
        check("ab_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (out_valid) ok = 1'b1;
        end
        check("ab_no_valid", ok, 0);
        check("ab_ready", in_ready, 1);
        offer(2, 2, 2, 2);
        wait_done(en_cnt, ok);
        check("ab_after_seen", ok, 1);
        check("ab_after_out_z", out_z, 16);
        take();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
